// File: rtl/reg_bank_reader.sv
// Read-side controller for the load/clear register bank: one-hot output enable, fixed-latency bus capture, valid/ready handoff.
// Optional even-parity output dout_par is built when READ_PARITY_EN is defined.
module reg_bank_reader #(
    parameter int N    = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            rd_req,
    input  logic [AW-1:0]   rd_addr,
    output logic            rd_busy,
    output logic [NREG-1:0] oe,
    input  logic [N-1:0]    bus,
    output logic [N-1:0]    dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            rd_err
`ifdef READ_PARITY_EN
    ,
    output logic            dout_par
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OE   = 2'd1,
        CAP  = 2'd2,
        VAL  = 2'd3
    } state_t;

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            err_q, err_d;
    logic [NREG-1:0] oe_q, oe_d;
    logic [N-1:0]    dout_q, dout_d;
    logic            valid_q, valid_d;
    logic            rd_err_q, rd_err_d;
    logic            busy_q, busy_d;
    logic            accept;
    logic            req_in_range;
`ifdef READ_PARITY_EN
    logic            par_q, par_d;
`endif

    function automatic logic [NREG-1:0] decode(input logic [AW-1:0] a);
        logic [NREG-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if ({1'b0, a} == (AW+1)'(i)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign req_in_range = ({1'b0, rd_addr} < NREG_W);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q;
        oe_d     = oe_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        rd_err_d = rd_err_q;
        accept   = 1'b0;
`ifdef READ_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                oe_d = '0;
                if (rd_req) begin
                    accept = 1'b1;
                end
            end
            OE: begin
                // Enable is re-derived from the latched address so later rd_addr changes cannot leak in.
                oe_d    = err_q ? '0 : decode(addr_q);
                state_d = CAP;
            end
            CAP: begin
                dout_d   = err_q ? '0 : bus;
                rd_err_d = err_q;
                valid_d  = 1'b1;
                oe_d     = '0;
                state_d  = VAL;
`ifdef READ_PARITY_EN
                par_d    = err_q ? 1'b0 : ^bus;
`endif
            end
            VAL: begin
                if (dout_ready) begin
                    valid_d  = 1'b0;
                    rd_err_d = 1'b0;
                    if (rd_req) begin
                        accept = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                oe_d    = '0;
            end
        endcase

        if (accept) begin
            addr_d  = rd_addr;
            err_d   = !req_in_range;
            oe_d    = req_in_range ? decode(rd_addr) : '0;
            state_d = OE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            err_q    <= 1'b0;
            oe_q     <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            rd_err_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            oe_q     <= oe_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            rd_err_q <= rd_err_d;
            busy_q   <= busy_d;
        end
    end

`ifdef READ_PARITY_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign dout_par = par_q;
`endif

    assign rd_busy    = busy_q;
    assign oe         = oe_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: a 4-register instance plus a 3-register instance for out-of-range reads.
// Both instances share the request side; each has its own bank model driving its bus from its oe.
module tb_reg_bank_reader;

    logic       clk;
    logic       clr_n;
    logic       rd_req;
    logic [1:0] rd_addr;
    logic       dout_ready;

    logic       busyA, validA, errA;
    logic [3:0] oeA;
    logic [3:0] busA, doutA;
    logic       busyB, validB, errB;
    logic [2:0] oeB;
    logic [3:0] busB, doutB;
`ifdef READ_PARITY_EN
    logic       parA, parB;
`endif

    logic [3:0] bank [4];

    int checks = 0;
    int errors = 0;

    reg_bank_reader #(.N(4), .NREG(4), .AW(2)) dut (
        .clk(clk), .clr_n(clr_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_busy(busyA), .oe(oeA), .bus(busA), .dout(doutA),
        .dout_valid(validA), .dout_ready(dout_ready), .rd_err(errA)
`ifdef READ_PARITY_EN
        , .dout_par(parA)
`endif
    );

    reg_bank_reader #(.N(4), .NREG(3), .AW(2)) dut3 (
        .clk(clk), .clr_n(clr_n), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_busy(busyB), .oe(oeB), .bus(busB), .dout(doutB),
        .dout_valid(validB), .dout_ready(dout_ready), .rd_err(errB)
`ifdef READ_PARITY_EN
        , .dout_par(parB)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: enabled registers drive the bus; an idle bus floats to all-ones.
    always_comb begin
        busA = (oeA == '0) ? 4'hF : 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (oeA[i]) busA = busA | bank[i];
        end
        busB = (oeB == '0) ? 4'hF : 4'h0;
        for (int i = 0; i < 3; i++) begin
            if (oeB[i]) busB = busB | bank[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic [1:0] addr, input logic rdy);
        rd_req     = req;
        rd_addr    = addr;
        dout_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    initial begin
        bank[0] = 4'h7;
        bank[1] = 4'hC;
        bank[2] = 4'hA;
        bank[3] = 4'h5;
        clr_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_oe", 32'(oeA), 32'h0);
        checkOutput("reset_dout", 32'(doutA), 32'h0);
        checkOutput("reset_valid", 32'(validA), 32'h0);
        checkOutput("reset_busy", 32'(busyA), 32'h0);
        checkOutput("reset_err", 32'(errA), 32'h0);
        #3 clr_n = 1'b1;

        // Reset in the middle of a read of reg2
        tick();
        applyStimulus(1'b1, 2'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("mid_oe_after_E0", 32'(oeA), 32'h4);
        checkOutput("mid_busy_after_E0", 32'(busyA), 32'h1);
        tick();
        clr_n = 1'b0;
        #1;
        checkOutput("mid_rst_oe", 32'(oeA), 32'h0);
        checkOutput("mid_rst_dout", 32'(doutA), 32'h0);
        checkOutput("mid_rst_valid", 32'(validA), 32'h0);
        checkOutput("mid_rst_busy", 32'(busyA), 32'h0);
        #2 clr_n = 1'b1;
        applyStimulus(1'b1, 2'd2, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();
        tick();
        checkOutput("mid_reread_dout", 32'(doutA), 32'hA);
        checkOutput("mid_reread_valid", 32'(validA), 32'h1);
        tick();
        checkOutput("mid_reread_handoff", 32'(validA), 32'h0);

        // Basic read of reg1 with the consumer always ready
        applyStimulus(1'b1, 2'd1, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd3, 1'b1);
        checkOutput("basic_oe_E0", 32'(oeA), 32'h2);
        tick();
        checkOutput("basic_oe_E1", 32'(oeA), 32'h2);
        tick();
        checkOutput("basic_dout", 32'(doutA), 32'hC);
        checkOutput("basic_valid", 32'(validA), 32'h1);
        checkOutput("basic_err", 32'(errA), 32'h0);
        checkOutput("basic_oe_E2", 32'(oeA), 32'h0);
`ifdef READ_PARITY_EN
        checkOutput("par_C", 32'(parA), 32'h0);
`endif
        tick();
        checkOutput("basic_valid_E3", 32'(validA), 32'h0);
        checkOutput("basic_busy_E3", 32'(busyA), 32'h0);
        checkOutput("basic_dout_hold", 32'(doutA), 32'hC);

        // Backpressure on a read of reg3; requests during the stall are dropped
        applyStimulus(1'b1, 2'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            applyStimulus((c == 1 || c == 3) ? 1'b1 : 1'b0, 2'd1, 1'b0);
            tick();
            checkOutput("bp_dout", 32'(doutA), 32'h5);
            checkOutput("bp_valid", 32'(validA), 32'h1);
            checkOutput("bp_oe", 32'(oeA), 32'h0);
        end
        applyStimulus(1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("bp_handoff_valid", 32'(validA), 32'h0);
        checkOutput("bp_handoff_busy", 32'(busyA), 32'h0);

        // Back-to-back: read reg1, then in VAL hand off and request reg3 on the same edge
        applyStimulus(1'b1, 2'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("b2b_first_dout", 32'(doutA), 32'hC);
        applyStimulus(1'b1, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("b2b_oe", 32'(oeA), 32'h8);
        checkOutput("b2b_valid_drop", 32'(validA), 32'h0);
        checkOutput("b2b_busy", 32'(busyA), 32'h1);
        tick();
        tick();
        checkOutput("b2b_second_dout", 32'(doutA), 32'h5);
        checkOutput("b2b_second_valid", 32'(validA), 32'h1);
        tick();

        // Out-of-range read of address 3 on the 3-register instance
        applyStimulus(1'b1, 2'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("oor_oe_E0", 32'(oeB), 32'h0);
        checkOutput("oor_busy", 32'(busyB), 32'h1);
        tick();
        checkOutput("oor_oe_E1", 32'(oeB), 32'h0);
        tick();
        checkOutput("oor_valid", 32'(validB), 32'h1);
        checkOutput("oor_dout", 32'(doutB), 32'h0);
        checkOutput("oor_err", 32'(errB), 32'h1);
        checkOutput("inr_err", 32'(errA), 32'h0);
`ifdef READ_PARITY_EN
        checkOutput("oor_par", 32'(parB), 32'h0);
`endif
        tick();
        checkOutput("oor_err_cleared", 32'(errB), 32'h0);
        checkOutput("oor_valid_cleared", 32'(validB), 32'h0);

        // Read reg0 (4'h7) on both instances
        applyStimulus(1'b1, 2'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd2, 1'b1);
        checkOutput("r0_oe3", 32'(oeB), 32'h1);
        tick();
        tick();
        checkOutput("r0_dout", 32'(doutA), 32'h7);
        checkOutput("r0_dout3", 32'(doutB), 32'h7);
        checkOutput("r0_err3", 32'(errB), 32'h0);
`ifdef READ_PARITY_EN
        checkOutput("par_7", 32'(parA), 32'h1);
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
